// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pong_pkg                                                     |
// | Description : Shared types and constants for the pong display pipeline:    |
// |               glyph geometry, glyph ROM address split, winner encoding     |
// |               and the BCD digit type with its wrap-around increment.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pong_pkg;

    // Glyph geometry in unscaled pixels
    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;

    // Glyph ROM address = {digit, line}
    localparam int GLYPH_COL_W = 3;   // log2(GLYPH_W)
    localparam int ROM_LINE_W  = 4;   // log2(GLYPH_H)
    localparam int ROM_DIGIT_W = 4;
    localparam int ROM_ADDR_W  = ROM_DIGIT_W + ROM_LINE_W;

    typedef logic [ROM_DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ZERO = 4'd0;
    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Bit 0 marks the left player, bit 1 the right player
    typedef enum logic [1:0] {
        WINNER_NONE  = 2'b00,
        WINNER_LEFT  = 2'b01,
        WINNER_RIGHT = 2'b10,
        WINNER_BOTH  = 2'b11
    } winner_e;

    // Single BCD digit increment, 9 wraps to 0
    function automatic bcd_digit_t bcd_wrap_inc(input bcd_digit_t d);
        return (d == BCD_NINE) ? BCD_ZERO : bcd_digit_t'(d + 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_text_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score_text_gen_if                                            |
// | Description : Signal bundle between the scoreboard stage and its           |
// |               neighbours: pixel stream in, game events in, glyph ROM       |
// |               address/data, and the aligned pixel/status outputs.          |
// |   master : pixel source, event source, glyph ROM and colour mixer side     |
// |   slave  : score_text_gen                                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface score_text_gen_if;
    import pong_pkg::*;

    logic [9:0]            pixel_x;
    logic [9:0]            pixel_y;
    logic                  video_on;
    logic                  frame_tick;
    logic                  point_left;
    logic                  point_right;
    logic                  clear_scores;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [GLYPH_W-1:0]    rom_data;
    logic                  text_on;
    logic                  video_on_d;
    logic                  game_over;
    logic [1:0]            winner;

    modport master (
        output pixel_x, pixel_y, video_on, frame_tick,
        output point_left, point_right, clear_scores,
        output rom_data,
        input  rom_addr, text_on, video_on_d, game_over, winner
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_tick,
        input  point_left, point_right, clear_scores,
        input  rom_data,
        output rom_addr, text_on, video_on_d, game_over, winner
    );

endinterface
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_score_counter                                            |
// | Description : Two-digit BCD score counter with clear, enable and           |
// |               increment. The next-state value is exported so the owner     |
// |               can detect a winning score in the same cycle it is written.  |
// | Ports       : clk, rst        - clock, synchronous active-high reset        |
// |               i_clear         - return to 00 (priority over increment)     |
// |               i_enable        - allow counting                             |
// |               i_inc           - add one point                              |
// |               o_tens/o_units  - registered score                           |
// |               o_next_*        - value to be loaded on the next edge        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bcd_score_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_inc,
    output bcd_digit_t o_tens,
    output bcd_digit_t o_units,
    output bcd_digit_t o_next_tens,
    output bcd_digit_t o_next_units
);

    bcd_digit_t r_tens;
    bcd_digit_t r_units;

    always_comb begin
        o_next_tens  = r_tens;
        o_next_units = r_units;
        if (i_clear) begin
            o_next_tens  = BCD_ZERO;
            o_next_units = BCD_ZERO;
        end else if (i_enable && i_inc) begin
            o_next_units = bcd_wrap_inc(r_units);
            // Carry into tens only when units roll over
            if (r_units == BCD_NINE) begin
                o_next_tens = bcd_wrap_inc(r_tens);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens  <= BCD_ZERO;
            r_units <= BCD_ZERO;
        end else begin
            r_tens  <= o_next_tens;
            r_units <= o_next_units;
        end
    end

    assign o_tens  = r_tens;
    assign o_units = r_units;

endmodule
`default_nettype wire

// File: rtl/score_text_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : score_text_gen                                               |
// | Description : Scoreboard stage of the pong display pipeline. Keeps the two |
// |               BCD scores, snapshots them at frame start, maps the pixel    |
// |               position to a glyph ROM address and realigns the returned    |
// |               glyph line with the pixel stream (2-cycle fixed latency).    |
// | Ports       : clk    - pixel clock                                         |
// |               reset  - synchronous active-high reset                       |
// |               bus    - slave side of score_text_gen_if (pixel stream,      |
// |                        game events, glyph ROM, text_on/video_on_d,         |
// |                        game_over/winner)                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module score_text_gen
    import pong_pkg::*;
#(
    parameter int TEXT_Y     = 16,
    parameter int LEFT_X     = 128,
    parameter int RIGHT_X    = 448,
    parameter int SCALE_LOG2 = 1,
    parameter int WIN_SCORE  = 11
)(
    input  logic              clk,
    input  logic              reset,
    score_text_gen_if.slave   bus
);

    // ------------------------------------------------------------------
    // Geometry constants (11-bit range bounds so the upper limits cannot wrap)
    // ------------------------------------------------------------------
    localparam int c_win_w  = (2 * GLYPH_W) << SCALE_LOG2;  // two glyphs wide
    localparam int c_text_h = GLYPH_H << SCALE_LOG2;

    localparam logic [10:0] c_y_lo  = 11'(TEXT_Y);
    localparam logic [10:0] c_y_hi  = 11'(TEXT_Y + c_text_h);
    localparam logic [10:0] c_lx_lo = 11'(LEFT_X);
    localparam logic [10:0] c_lx_hi = 11'(LEFT_X + c_win_w);
    localparam logic [10:0] c_rx_lo = 11'(RIGHT_X);
    localparam logic [10:0] c_rx_hi = 11'(RIGHT_X + c_win_w);

    localparam logic [9:0]  c_text_y    = 10'(TEXT_Y);
    localparam logic [9:0]  c_left_base = 10'(LEFT_X);
    localparam logic [9:0]  c_right_base = 10'(RIGHT_X);

    localparam bcd_digit_t  c_win_tens  = 4'(WIN_SCORE / 10);
    localparam bcd_digit_t  c_win_units = 4'(WIN_SCORE % 10);

    localparam int          c_slot_bit  = GLYPH_COL_W + SCALE_LOG2;

    // ------------------------------------------------------------------
    // Score counters
    // ------------------------------------------------------------------
    logic       r_game_over;
    winner_e    r_winner;
    logic       w_count_en;

    bcd_digit_t w_left_tens,  w_left_units,  w_left_next_tens,  w_left_next_units;
    bcd_digit_t w_right_tens, w_right_units, w_right_next_tens, w_right_next_units;

    assign w_count_en = ~r_game_over;

    bcd_score_counter u_left_score (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (bus.clear_scores),
        .i_enable     (w_count_en),
        .i_inc        (bus.point_left),
        .o_tens       (w_left_tens),
        .o_units      (w_left_units),
        .o_next_tens  (w_left_next_tens),
        .o_next_units (w_left_next_units)
    );

    bcd_score_counter u_right_score (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (bus.clear_scores),
        .i_enable     (w_count_en),
        .i_inc        (bus.point_right),
        .o_tens       (w_right_tens),
        .o_units      (w_right_units),
        .o_next_tens  (w_right_next_tens),
        .o_next_units (w_right_next_units)
    );

    // ------------------------------------------------------------------
    // Game-over detection
    // Looking at the counters' next values lets game_over rise on the same
    // edge that loads the winning score, so no further point can slip in.
    // ------------------------------------------------------------------
    logic w_left_at_win;
    logic w_right_at_win;

    assign w_left_at_win  = (w_left_next_tens  == c_win_tens) && (w_left_next_units  == c_win_units);
    assign w_right_at_win = (w_right_next_tens == c_win_tens) && (w_right_next_units == c_win_units);

    always_ff @(posedge clk) begin
        if (reset || bus.clear_scores) begin
            r_game_over <= 1'b0;
            r_winner    <= WINNER_NONE;
        end else if (!r_game_over && (w_left_at_win || w_right_at_win)) begin
            r_game_over <= 1'b1;
            r_winner    <= winner_e'({w_right_at_win, w_left_at_win});
        end
    end

    // ------------------------------------------------------------------
    // Frame snapshot: the image only changes at frame start. Registered
    // scores are copied, so a same-cycle point shows up one frame later.
    // ------------------------------------------------------------------
    bcd_digit_t r_disp_left_tens,  r_disp_left_units;
    bcd_digit_t r_disp_right_tens, r_disp_right_units;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_left_tens   <= BCD_ZERO;
            r_disp_left_units  <= BCD_ZERO;
            r_disp_right_tens  <= BCD_ZERO;
            r_disp_right_units <= BCD_ZERO;
        end else if (bus.frame_tick) begin
            r_disp_left_tens   <= w_left_tens;
            r_disp_left_units  <= w_left_units;
            r_disp_right_tens  <= w_right_tens;
            r_disp_right_units <= w_right_units;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: pixel -> glyph ROM address
    // ------------------------------------------------------------------
    logic                   w_in_y;
    logic                   w_in_left;
    logic                   w_in_right;
    logic [9:0]             w_dx;
    logic [9:0]             w_dy;
    logic                   w_slot;      // 0 = tens glyph, 1 = units glyph
    logic [GLYPH_COL_W-1:0] w_col;
    logic [ROM_LINE_W-1:0]  w_line;
    bcd_digit_t             w_digit;
    logic                   w_hit_raw;
    logic                   w_hit;
    logic                   w_unused_bits;

    always_comb begin
        w_in_y     = ({1'b0, bus.pixel_y} >= c_y_lo)  && ({1'b0, bus.pixel_y} < c_y_hi);
        w_in_left  = ({1'b0, bus.pixel_x} >= c_lx_lo) && ({1'b0, bus.pixel_x} < c_lx_hi);
        w_in_right = ({1'b0, bus.pixel_x} >= c_rx_lo) && ({1'b0, bus.pixel_x} < c_rx_hi);

        // Offsets may wrap when out of range; they are only used on a hit
        w_dx   = w_in_left ? (bus.pixel_x - c_left_base) : (bus.pixel_x - c_right_base);
        w_dy   = bus.pixel_y - c_text_y;

        w_slot = w_dx[c_slot_bit];
        w_col  = w_dx[SCALE_LOG2 +: GLYPH_COL_W];
        w_line = w_dy[SCALE_LOG2 +: ROM_LINE_W];

        if (w_in_left) begin
            w_digit = w_slot ? r_disp_left_units : r_disp_left_tens;
        end else begin
            w_digit = w_slot ? r_disp_right_units : r_disp_right_tens;
        end

        w_hit_raw = bus.video_on && w_in_y && (w_in_left || w_in_right);

        // Leading-zero suppression blanks the pixel but keeps the ROM address
        w_hit     = w_hit_raw && !(!w_slot && (w_digit == BCD_ZERO));

        bus.rom_addr = w_hit_raw ? {w_digit, w_line} : '0;
    end

    // Out-of-window offset bits are deliberately discarded
    assign w_unused_bits = ^{w_dx, w_dy};

    // ------------------------------------------------------------------
    // Stage 1: hold hit/column while the ROM performs its registered read
    // Stage 2: pick the glyph bit (MSB is the leftmost column)
    // ------------------------------------------------------------------
    logic                   r_hit_d1;
    logic [GLYPH_COL_W-1:0] r_col_d1;
    logic                   r_video_on_d1;
    logic                   r_text_on;
    logic                   r_video_on_d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_d1      <= 1'b0;
            r_col_d1      <= '0;
            r_video_on_d1 <= 1'b0;
            r_text_on     <= 1'b0;
            r_video_on_d2 <= 1'b0;
        end else begin
            r_hit_d1      <= w_hit;
            r_col_d1      <= w_col;
            r_video_on_d1 <= bus.video_on;
            r_text_on     <= r_hit_d1 & bus.rom_data[GLYPH_COL_W'(GLYPH_W - 1) - r_col_d1];
            r_video_on_d2 <= r_video_on_d1;
        end
    end

    assign bus.text_on    = r_text_on;
    assign bus.video_on_d = r_video_on_d2;
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_text_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_score_text_gen                                            |
// | Description : Self-checking bench for score_text_gen: table-driven pixel   |
// |               vectors, directed game sequences and randomized traffic      |
// |               against a decimal-arithmetic reference model.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_score_text_gen;

    localparam int TEXT_Y     = 16;
    localparam int LEFT_X     = 128;
    localparam int RIGHT_X    = 448;
    localparam int SCALE_LOG2 = 1;
    localparam int WIN_SCORE  = 11;
    localparam int SC         = 1 << SCALE_LOG2;

    logic clk;
    logic reset;

    score_text_gen_if bus ();

    score_text_gen #(
        .TEXT_Y     (TEXT_Y),
        .LEFT_X     (LEFT_X),
        .RIGHT_X    (RIGHT_X),
        .SCALE_LOG2 (SCALE_LOG2),
        .WIN_SCORE  (WIN_SCORE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph ROM stand-in: arbitrary but address-dependent pattern
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        return a ^ 8'hC3;
    endfunction

    always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

    int tests;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int       sl, sr;          // scores
    int       dl, dr;          // displayed scores
    bit       go;
    logic [1:0] win;
    bit       p1, p2, v1, v2;  // expected text_on / video_on pipeline

    task automatic model_reset();
        sl = 0; sr = 0; dl = 0; dr = 0; go = 0; win = 2'b00;
        p1 = 0; p2 = 0; v1 = 0; v2 = 0;
    endtask

    // Pixel rule computed with plain decimal arithmetic
    function automatic void model_pixel(input int x, input int y, input bit v,
                                        input int disp_l, input int disp_r,
                                        output logic [7:0] addr, output bit on);
        int base, score, dx, slot, col, line, dig;
        logic [7:0] g;
        addr = 8'h00;
        on   = 1'b0;
        if (!v || y < TEXT_Y || y >= TEXT_Y + 16 * SC) return;
        if (x >= LEFT_X && x < LEFT_X + 16 * SC) begin
            base = LEFT_X;  score = disp_l;
        end else if (x >= RIGHT_X && x < RIGHT_X + 16 * SC) begin
            base = RIGHT_X; score = disp_r;
        end else begin
            return;
        end
        dx   = x - base;
        slot = dx / (8 * SC);
        col  = (dx / SC) % 8;
        line = (y - TEXT_Y) / SC;
        dig  = (slot == 0) ? score / 10 : score % 10;
        addr = 8'(dig * 16 + line);
        g    = rom_fn(addr);
        on   = !(slot == 0 && dig == 0) && g[7 - col];
    endfunction

    task automatic set_pix(input int x, input int y, input bit v);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = v;
    endtask

    // One clock: check combinational address, advance, update model, check outputs
    task automatic tick();
        logic [7:0] m_addr;
        bit         m_on;
        #1;
        model_pixel(int'(bus.pixel_x), int'(bus.pixel_y), bus.video_on, dl, dr, m_addr, m_on);
        check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (bus.frame_tick) begin
                dl = sl; dr = sr;
            end
            if (bus.clear_scores) begin
                sl = 0; sr = 0; go = 0; win = 2'b00;
            end else if (!go) begin
                if (bus.point_left)  sl++;
                if (bus.point_right) sr++;
                if (sl == WIN_SCORE || sr == WIN_SCORE) begin
                    go  = 1;
                    win = {sr == WIN_SCORE, sl == WIN_SCORE};
                end
            end
            p2 = p1; p1 = m_on;
            v2 = v1; v1 = bus.video_on;
        end
        bus.point_left   = 1'b0;
        bus.point_right  = 1'b0;
        bus.clear_scores = 1'b0;
        bus.frame_tick   = 1'b0;
        check("text_on",    32'(bus.text_on),    32'(p2));
        check("video_on_d", 32'(bus.video_on_d), 32'(v2));
        check("game_over",  32'(bus.game_over),  32'(go));
        check("winner",     32'(bus.winner),     32'(win));
    endtask

    task automatic pulse_left();
        bus.point_left = 1'b1; tick(); tick();
    endtask

    task automatic snap();
        bus.frame_tick = 1'b1; tick();
    endtask

    task automatic addr_at(input string name, input int x, input int y, input logic [7:0] exp);
        set_pix(x, y, 1'b1);
        #1;
        check(name, 32'(bus.rom_addr), 32'(exp));
        tick();
    endtask

    typedef struct {
        int         x;
        int         y;
        bit         v;
        logic [7:0] addr;
        bit         on;
    } vec_t;

    vec_t vecs[13];

    initial begin
        tests = 0;
        failures = 0;

        // Display 07 / 00 expected for these vectors
        vecs[0]  = '{148, 20, 1'b1, 8'h72, 1'b1};  // units 7, col 2
        vecs[1]  = '{130, 20, 1'b1, 8'h02, 1'b0};  // tens 0 suppressed
        vecs[2]  = '{159, 20, 1'b1, 8'h72, 1'b1};  // LEFT_X+31: col 7
        vecs[3]  = '{160, 20, 1'b1, 8'h00, 1'b0};  // LEFT_X+32: outside
        vecs[4]  = '{127, 20, 1'b1, 8'h00, 1'b0};  // just left of window
        vecs[5]  = '{144, 16, 1'b1, 8'h70, 1'b1};  // first column/row of units
        vecs[6]  = '{144, 47, 1'b1, 8'h7F, 1'b1};  // last row of band
        vecs[7]  = '{144, 48, 1'b1, 8'h00, 1'b0};  // below band
        vecs[8]  = '{144, 15, 1'b1, 8'h00, 1'b0};  // above band
        vecs[9]  = '{148, 20, 1'b0, 8'h00, 1'b0};  // blanking
        vecs[10] = '{466, 20, 1'b1, 8'h02, 1'b1};  // right units 0, col 1
        vecs[11] = '{470, 20, 1'b1, 8'h02, 1'b0};  // right units 0, col 3
        vecs[12] = '{450, 30, 1'b1, 8'h07, 1'b0};  // right tens 0 suppressed

        reset = 1'b1;
        bus.frame_tick = 1'b0; bus.point_left = 1'b0; bus.point_right = 1'b0;
        bus.clear_scores = 1'b0;
        set_pix(0, 0, 1'b0);
        model_reset();

        // Reset state
        repeat (3) tick();
        reset = 1'b0;

        // Score band sweep at 00/00
        snap();
        for (int y = 12; y < 52; y++) begin
            for (int x = 124; x < 164; x++) begin set_pix(x, y, 1'b1); tick(); end
            for (int x = 444; x < 484; x++) begin set_pix(x, y, 1'b1); tick(); end
        end
        set_pix(0, 0, 1'b0); tick(); tick();

        // Left score 07, table-driven pixel vectors
        repeat (7) pulse_left();
        snap();
        foreach (vecs[i]) begin
            set_pix(vecs[i].x, vecs[i].y, vecs[i].v);
            #1;
            check($sformatf("tbl%0d_addr", i), 32'(bus.rom_addr), 32'(vecs[i].addr));
            tick();
            set_pix(0, 0, 1'b0);
            tick();
            check($sformatf("tbl%0d_text", i), 32'(bus.text_on), 32'(vecs[i].on));
        end

        // Left wins at 11; 12th point ignored
        bus.clear_scores = 1'b1; tick();
        repeat (11) pulse_left();
        check("left_win_go",  32'(bus.game_over), 32'd1);
        check("left_win_who", 32'(bus.winner),    32'd1);
        pulse_left();
        snap();
        addr_at("held_units", 148, 20, 8'h12);
        addr_at("held_tens",  132, 20, 8'h12);
        bus.clear_scores = 1'b1; tick();
        check("clear_go",  32'(bus.game_over), 32'd0);
        check("clear_who", 32'(bus.winner),    32'd0);
        snap();
        addr_at("clear_units", 148, 20, 8'h02);

        // 10/10 then simultaneous point
        repeat (10) begin bus.point_left = 1'b1; bus.point_right = 1'b1; tick(); end
        check("ten_ten_go", 32'(bus.game_over), 32'd0);
        bus.point_left = 1'b1; bus.point_right = 1'b1; tick();
        check("both_go",  32'(bus.game_over), 32'd1);
        check("both_who", 32'(bus.winner),    32'd3);

        // Clear wins over a same-cycle point
        bus.clear_scores = 1'b1; bus.point_left = 1'b1; tick();
        snap();
        addr_at("clr_pt_units", 148, 20, 8'h02);

        // Mid-frame point does not tear; same-cycle frame_tick sees old value
        pulse_left();
        addr_at("midframe_old", 148, 20, 8'h02);
        bus.frame_tick = 1'b1; bus.point_left = 1'b1; tick();
        addr_at("tick_pre_inc", 148, 20, 8'h12);
        snap();
        addr_at("tick_next",    148, 20, 8'h22);

        // Reset in mid-scan on a lit pixel (units 2, col 0 -> 0x20^C3 bit7 = 1)
        set_pix(144, 16, 1'b1);
        tick(); tick();
        check("pre_reset_on", 32'(bus.text_on), 32'd1);
        reset = 1'b1; tick();
        check("rst_text0", 32'(bus.text_on), 32'd0);
        reset = 1'b0; tick();
        check("rst_text1", 32'(bus.text_on), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int x, y;
            if ($urandom_range(0, 1) == 0) x = $urandom_range(120, 168);
            else                           x = $urandom_range(440, 488);
            y = $urandom_range(10, 54);
            set_pix(x, y, ($urandom_range(0, 7) != 0));
            bus.point_left   = ($urandom_range(0, 19) == 0);
            bus.point_right  = ($urandom_range(0, 19) == 0);
            bus.clear_scores = ($urandom_range(0, 299) == 0);
            bus.frame_tick   = ($urandom_range(0, 59) == 0);
            reset            = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
